// File: rtl/pcie_datalink_pkg.sv
// ---------------------------------------------------------------------------
// pcie_datalink_pkg
// Shared definitions for the DLLP flow-control receive path.
//   - dllp_type_e   : DLLP type codes for InitFC1/InitFC2/UpdateFC per class
//   - rx_state_e    : receive framing states (header beat, CRC beat, drop)
//   - dllp_fc_t     : decoded fields of a flow-control DLLP beat 0
//   - credit widths : 8-bit header credits, 12-bit data credits
//   - bit_rev8      : byte bit-reversal used for the on-wire CRC ordering
// ---------------------------------------------------------------------------
package pcie_datalink_pkg;

   localparam int HDR_CREDIT_W   = 8;
   localparam int DATA_CREDIT_W  = 12;
   localparam int NUM_FC_CLASSES = 3;

   // Credit class index, taken from the two low bits of the DLLP type
   localparam int FC_IDX_P   = 0;
   localparam int FC_IDX_NP  = 1;
   localparam int FC_IDX_CPL = 2;

   localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
   localparam logic [15:0] DLLP_CRC_INIT = 16'hFFFF;

   typedef enum logic [3:0] {
      DLLP_INITFC1_P   = 4'h4,
      DLLP_INITFC1_NP  = 4'h5,
      DLLP_INITFC1_CPL = 4'h6,
      DLLP_UPDATEFC_P  = 4'h8,
      DLLP_UPDATEFC_NP = 4'h9,
      DLLP_UPDATEFC_CPL = 4'hA,
      DLLP_INITFC2_P   = 4'hC,
      DLLP_INITFC2_NP  = 4'hD,
      DLLP_INITFC2_CPL = 4'hE
   } dllp_type_e;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_CRC  = 2'd1,
      ST_DROP = 2'd2
   } rx_state_e;

   typedef struct packed {
      logic [3:0]               dllp_type;
      logic [2:0]               vc;
      logic [HDR_CREDIT_W-1:0]  hdr;
      logic [DATA_CREDIT_W-1:0] data;
   } dllp_fc_t;

   // The CRC travels with each byte bit-reversed relative to the LFSR value
   function automatic logic [7:0] bit_rev8(input logic [7:0] value);
      logic [7:0] result;
      result = '0;
      for (int i = 0; i < 8; i++) begin
         result[i] = value[7-i];
      end
      return result;
   endfunction

endpackage

// File: rtl/pcie_datalink_crc.sv
// ---------------------------------------------------------------------------
// pcie_datalink_crc
// Combinational 16-bit DLLP CRC LFSR (polynomial 0x100B) advanced over one
// 32-bit word. Bits enter byte 0 first, least-significant bit first, which is
// the serial order of the DLLP on the link.
// Ports:
//   crc_in  [15:0]  starting LFSR value (all ones for a fresh DLLP)
//   data    [31:0]  DLLP bytes 0..3, byte 0 in data[7:0]
//   crc_out [15:0]  LFSR value after all 32 bits (not yet complemented)
// ---------------------------------------------------------------------------
module pcie_datalink_crc
   import pcie_datalink_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [31:0] data,
   output logic [15:0] crc_out
);

   logic [15:0] lfsr;
   logic        feedback;

   // Unrolled serial LFSR: one shift per data bit in wire order
   always_comb begin
      lfsr     = crc_in;
      feedback = 1'b0;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            feedback = lfsr[15] ^ data[8*b + i];
            lfsr     = {lfsr[14:0], 1'b0} ^ (feedback ? DLLP_CRC_POLY : 16'h0000);
         end
      end
      crc_out = lfsr;
   end

endmodule

// File: rtl/pcie_flow_ctrl_rx.sv
// ---------------------------------------------------------------------------
// pcie_flow_ctrl_rx
// Receive side of DLLP flow-control initialisation. Consumes two-beat DLLPs
// (beat 0 = DLLP bytes 0..3, beat 1 = CRC), decodes InitFC1/InitFC2/UpdateFC
// for the configured VC, stores the partner's advertised credits per class
// and raises the FC1/FC2 "values stored" flags for the FC init transmitter.
//
// Optional feature macro: DLLP_RX_CRC_CHECK_EN
//   defined   -> CRC beat compared, mismatching DLLPs discarded and counted
//   undefined -> CRC beat consumed unchecked, crc_err_cnt_o tied to zero
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   link_up_i              low clears credits and flags (synchronous)
//   s_axis_*               DLLP stream in; tready is 1 whenever out of reset
//   fc1_values_stored_o    all three classes received via InitFC1/InitFC2
//   fc2_values_stored_o    InitFC2/UpdateFC seen after FC1 complete
//   *h_credits_o [7:0]     header credits  (P, NP, Cpl)
//   *d_credits_o [11:0]    data credits    (P, NP, Cpl)
//   crc_err_cnt_o [15:0]   saturating CRC error count (kept across link down)
// ---------------------------------------------------------------------------
module pcie_flow_ctrl_rx
   import pcie_datalink_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int USER_WIDTH = 3,
   parameter int VC_ID      = 0
)(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     link_up_i,
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   input  logic [USER_WIDTH-1:0]    s_axis_tuser,
   output logic                     s_axis_tready,
   output logic                     fc1_values_stored_o,
   output logic                     fc2_values_stored_o,
   output logic [HDR_CREDIT_W-1:0]  ph_credits_o,
   output logic [HDR_CREDIT_W-1:0]  nph_credits_o,
   output logic [HDR_CREDIT_W-1:0]  cplh_credits_o,
   output logic [DATA_CREDIT_W-1:0] pd_credits_o,
   output logic [DATA_CREDIT_W-1:0] npd_credits_o,
   output logic [DATA_CREDIT_W-1:0] cpld_credits_o,
   output logic [15:0]              crc_err_cnt_o
);

   localparam logic [2:0] VC_SEL = 3'(VC_ID);

   rx_state_e state_q, state_d;
   logic      ready_q;
   logic      beat;
   logic      hdr_load;
   logic      commit;
   logic      crc_bad;
   logic      crc_match;
   dllp_fc_t  fc_q;
   dllp_fc_t  fc_in;

   logic [NUM_FC_CLASSES-1:0][HDR_CREDIT_W-1:0]  hdr_q, hdr_d;
   logic [NUM_FC_CLASSES-1:0][DATA_CREDIT_W-1:0] data_q, data_d;
   logic [NUM_FC_CLASSES-1:0]                    got_q, got_d;
   logic fc1_q, fc1_d;
   logic fc2_q, fc2_d;
   logic is_init, is_init2, is_update;

   // tkeep and tuser carry nothing this block needs; several tdata bits are
   // reserved fields of the DLLP
   logic unused_inputs;

   assign s_axis_tready = ready_q;
   assign beat          = s_axis_tvalid & ready_q;

   // Field extraction of DLLP beat 0 (byte0 = tdata[7:0])
   always_comb begin
      fc_in           = '0;
      fc_in.dllp_type = s_axis_tdata[7:4];
      fc_in.vc        = s_axis_tdata[2:0];
      fc_in.hdr       = {s_axis_tdata[13:8], s_axis_tdata[23:22]};
      fc_in.data      = {s_axis_tdata[19:16], s_axis_tdata[31:24]};
   end

`ifdef DLLP_RX_CRC_CHECK_EN
   logic [15:0] crc_lfsr;
   logic [15:0] crc_q;
   logic [15:0] crc_exp;
   logic [15:0] err_cnt_q;

   pcie_datalink_crc u_crc (
      .crc_in  (DLLP_CRC_INIT),
      .data    (s_axis_tdata[31:0]),
      .crc_out (crc_lfsr)
   );

   // The transmitted CRC is the complemented LFSR, high byte first on the
   // wire, and each byte bit-reversed
   assign crc_exp   = ~crc_q;
   assign crc_match = (s_axis_tdata[15:0] ==
                       {bit_rev8(crc_exp[7:0]), bit_rev8(crc_exp[15:8])});

   // CRC of beat 0 is held until the CRC beat arrives; the error counter
   // saturates and deliberately survives link down
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         if (hdr_load) begin
            crc_q <= crc_lfsr;
         end
         if (crc_bad && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign crc_err_cnt_o = err_cnt_q;
   assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser, s_axis_tdata};
`else
   assign crc_match     = 1'b1;
   assign crc_err_cnt_o = 16'h0000;
   assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser, s_axis_tdata, crc_bad};
`endif

   // Framing FSM: beat 0 is captured in ST_HDR, the CRC beat decides commit in
   // ST_CRC, and anything longer than two beats is flushed through ST_DROP.
   // Link down forces the FSM back to waiting for a fresh beat 0.
   always_comb begin
      state_d  = state_q;
      hdr_load = 1'b0;
      commit   = 1'b0;
      crc_bad  = 1'b0;
      case (state_q)
         ST_HDR: begin
            if (beat && !s_axis_tlast) begin
               hdr_load = 1'b1;
               state_d  = ST_CRC;
            end
         end
         ST_CRC: begin
            if (beat) begin
               if (s_axis_tlast) begin
                  state_d = ST_HDR;
                  if (!crc_match) begin
                     crc_bad = 1'b1;
                  end else if (fc_q.vc == VC_SEL) begin
                     commit = 1'b1;
                  end
               end else begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (beat && s_axis_tlast) begin
               state_d = ST_HDR;
            end
         end
         default: begin
            state_d = ST_HDR;
         end
      endcase
      if (!link_up_i) begin
         state_d  = ST_HDR;
         hdr_load = 1'b0;
         commit   = 1'b0;
         crc_bad  = 1'b0;
      end
   end

   // Credit bookkeeping on a committed DLLP. InitFC values are taken once per
   // class until FC1 completes; UpdateFC only overwrites after FC2, with a
   // zero value meaning infinite and passed straight through. FC2 is set by
   // the first InitFC2 or UpdateFC that arrives while FC1 is already stored.
   always_comb begin
      hdr_d     = hdr_q;
      data_d    = data_q;
      got_d     = got_q;
      fc2_d     = fc2_q;
      is_init   = 1'b0;
      is_init2  = 1'b0;
      is_update = 1'b0;
      case (fc_q.dllp_type)
         DLLP_INITFC1_P, DLLP_INITFC1_NP, DLLP_INITFC1_CPL: begin
            is_init = 1'b1;
         end
         DLLP_INITFC2_P, DLLP_INITFC2_NP, DLLP_INITFC2_CPL: begin
            is_init  = 1'b1;
            is_init2 = 1'b1;
         end
         DLLP_UPDATEFC_P, DLLP_UPDATEFC_NP, DLLP_UPDATEFC_CPL: begin
            is_update = 1'b1;
         end
         default: begin
         end
      endcase
      for (int c = 0; c < NUM_FC_CLASSES; c++) begin
         if (commit && (fc_q.dllp_type[1:0] == 2'(c))) begin
            if (is_init && !fc1_q && !got_q[c]) begin
               hdr_d[c]  = fc_q.hdr;
               data_d[c] = fc_q.data;
               got_d[c]  = 1'b1;
            end
            if (is_update && fc2_q) begin
               hdr_d[c]  = fc_q.hdr;
               data_d[c] = fc_q.data;
            end
         end
      end
      if (commit && (is_init2 || is_update) && fc1_q) begin
         fc2_d = 1'b1;
      end
      fc1_d = &got_d;
      if (!link_up_i) begin
         hdr_d  = '0;
         data_d = '0;
         got_d  = '0;
         fc1_d  = 1'b0;
         fc2_d  = 1'b0;
      end
   end

   // State, captured beat 0 and all credit/flag registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_HDR;
         ready_q <= 1'b0;
         fc_q    <= '0;
         hdr_q   <= '0;
         data_q  <= '0;
         got_q   <= '0;
         fc1_q   <= 1'b0;
         fc2_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
         if (hdr_load) begin
            fc_q <= fc_in;
         end
         hdr_q  <= hdr_d;
         data_q <= data_d;
         got_q  <= got_d;
         fc1_q  <= fc1_d;
         fc2_q  <= fc2_d;
      end
   end

   assign fc1_values_stored_o = fc1_q;
   assign fc2_values_stored_o = fc2_q;
   assign ph_credits_o        = hdr_q[FC_IDX_P];
   assign nph_credits_o       = hdr_q[FC_IDX_NP];
   assign cplh_credits_o      = hdr_q[FC_IDX_CPL];
   assign pd_credits_o        = data_q[FC_IDX_P];
   assign npd_credits_o       = data_q[FC_IDX_NP];
   assign cpld_credits_o      = data_q[FC_IDX_CPL];

endmodule
